imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 184 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : RISC-V immediate generator with a registered main entry and a
//               one-deep skid entry on a valid/ready output interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
  parameter int         XLEN       = 32,
  parameter bit         PIM_EN     = 1'b1,
  parameter logic [6:0] PIM_OPCODE = 7'b0001011
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic            illegal_o,
  output logic [31:0]     instr_o
);

  localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] c_OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
  localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
  localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;

  localparam logic [2:0] c_T_NONE  = 3'd0;
  localparam logic [2:0] c_T_I     = 3'd1;
  localparam logic [2:0] c_T_S     = 3'd2;
  localparam logic [2:0] c_T_B     = 3'd3;
  localparam logic [2:0] c_T_U     = 3'd4;
  localparam logic [2:0] c_T_J     = 3'd5;
  localparam logic [2:0] c_T_SHAMT = 3'd6;

  // Entry layout: {imm, type, illegal, instr}
  localparam int c_EW = XLEN + 3 + 1 + 32;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_shamt5;
  logic            w_is_shift;
  logic            w_pim_hit;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_type;
  logic            w_illegal;
  logic [c_EW-1:0] w_dec;

  logic [c_EW-1:0] r_main;
  logic [c_EW-1:0] r_skid;
  logic            r_m_valid;
  logic            r_s_valid;
  logic            r_in_ready;

  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_m_free;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];

  assign w_imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign w_imm_s  = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_imm_b  = {{(XLEN-13){instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_imm_j  = {{(XLEN-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
  assign w_imm_u  = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
  // Bit 5 of the shift amount only exists on 64-bit datapaths
  assign w_shamt  = {{(XLEN-6){1'b0}}, (XLEN == 64) ? instr_i[25] : 1'b0,
                     instr_i[24:20]};
  assign w_shamt5 = {{(XLEN-5){1'b0}}, instr_i[24:20]};

  assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
  assign w_pim_hit  = PIM_EN && (w_opcode == PIM_OPCODE);

  always_comb begin
    w_imm  = '0;
    w_type = c_T_NONE;
    if (w_pim_hit) begin
      w_imm  = w_imm_s;
      w_type = c_T_S;
    end else begin
      case (w_opcode)
        c_OPC_OP_IMM: begin
          w_imm  = w_is_shift ? w_shamt : w_imm_i;
          w_type = w_is_shift ? c_T_SHAMT : c_T_I;
        end
        c_OPC_OP_IMM32: begin
          if (XLEN == 64) begin
            w_imm  = w_is_shift ? w_shamt5 : w_imm_i;
            w_type = w_is_shift ? c_T_SHAMT : c_T_I;
          end
        end
        c_OPC_LOAD, c_OPC_JALR: begin
          w_imm  = w_imm_i;
          w_type = c_T_I;
        end
        c_OPC_STORE: begin
          w_imm  = w_imm_s;
          w_type = c_T_S;
        end
        c_OPC_BRANCH: begin
          w_imm  = w_imm_b;
          w_type = c_T_B;
        end
        c_OPC_JAL: begin
          w_imm  = w_imm_j;
          w_type = c_T_J;
        end
        c_OPC_LUI, c_OPC_AUIPC: begin
          w_imm  = w_imm_u;
          w_type = c_T_U;
        end
        default: begin
          w_imm  = '0;
          w_type = c_T_NONE;
        end
      endcase
    end
  end

  assign w_illegal = (w_type == c_T_NONE);
  assign w_dec     = {w_imm, w_type, w_illegal, instr_i};

  assign w_in_xfer  = in_valid_i & r_in_ready;
  assign w_out_xfer = r_m_valid & out_ready_i;
  assign w_m_free   = ~r_m_valid | w_out_xfer;

  // r_in_ready tracks ~r_s_valid; while the skid is full no input can arrive,
  // so a draining main always refills from the skid first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (flush_i) begin
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_m_free) begin
      if (r_s_valid) begin
        r_main     <= r_skid;
        r_m_valid  <= 1'b1;
        r_s_valid  <= 1'b0;
        r_in_ready <= 1'b1;
      end else begin
        r_m_valid <= w_in_xfer;
        if (w_in_xfer) begin
          r_main <= w_dec;
        end
      end
    end else if (w_in_xfer) begin
      r_skid     <= w_dec;
      r_s_valid  <= 1'b1;
      r_in_ready <= 1'b0;
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_m_valid;
  assign {imm_o, imm_type_o, illegal_o, instr_o} = r_main;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Scoreboard bench for imm_gen_pipe (XLEN=32, XLEN=64, PIM off).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] e64;
    logic [31:0] e32;
    logic [2:0]  t32;
    logic [2:0]  t64;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [31:0] imm0, imm2;
  logic [63:0] imm1;
  logic [2:0]  typ0, typ1, typ2;
  logic        ill0, ill1, ill2;
  logic [31:0] io0, io1, io2;

  vec_t vecs[16];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .PIM_EN(1'b1), .PIM_OPCODE(7'b0001011)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready0), .instr_i(instr), .out_valid_o(out_valid0),
    .out_ready_i(out_ready), .imm_o(imm0), .imm_type_o(typ0),
    .illegal_o(ill0), .instr_o(io0));

  imm_gen_pipe #(.XLEN(64), .PIM_EN(1'b1), .PIM_OPCODE(7'b0001011)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready1), .instr_i(instr), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .imm_o(imm1), .imm_type_o(typ1),
    .illegal_o(ill1), .instr_o(io1));

  imm_gen_pipe #(.XLEN(32), .PIM_EN(1'b0), .PIM_OPCODE(7'b0001011)) u_dutnp (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready2), .instr_i(instr), .out_valid_o(out_valid2),
    .out_ready_i(out_ready), .imm_o(imm2), .imm_type_o(typ2),
    .illegal_o(ill2), .instr_o(io2));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string name, input exp_t e, input logic [63:0] imm,
                           input logic [2:0] typ, input logic ill, input logic [31:0] io);
    n_total++;
    if (imm === e.imm && typ === e.typ && ill === e.ill && io === e.instr) n_pass++;
    else $display("FAIL %s out: got instr=%h imm=%h type=%0d ill=%0b, expected instr=%h imm=%h type=%0d ill=%0b",
                  name, io, imm, typ, ill, e.instr, e.imm, e.typ, e.ill);
  endtask

  function automatic void push_exp(input int idx);
    exp_t e;
    e.instr = vecs[idx].instr;
    e.imm   = {32'b0, vecs[idx].e32};
    e.typ   = vecs[idx].t32;
    e.ill   = (vecs[idx].t32 == 3'd0);
    q0.push_back(e);
    // PIM disabled: the custom opcode decodes as illegal
    if (vecs[idx].instr[6:0] == 7'b0001011) begin
      e.imm = '0;
      e.typ = 3'd0;
      e.ill = 1'b1;
    end
    q2.push_back(e);
    e.imm = vecs[idx].e64;
    e.typ = vecs[idx].t64;
    e.ill = (vecs[idx].t64 == 3'd0);
    q1.push_back(e);
  endfunction

  // One clock of stimulus; returns whether the offered input was accepted
  task automatic cyc(input logic v, input int idx, input logic rdy, input logic fl,
                     output logic acc);
    in_valid  = v;
    instr     = vecs[idx].instr;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    acc = v && in_ready0 && !fl;
    if (acc) push_exp(idx);
    if (fl) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic send(input int idx, input logic rdy);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cyc(1'b1, idx, rdy, 1'b0, acc);
    check("send_accept", acc, 1'b1);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && !flush && out_ready) begin
      if (out_valid0) begin
        if (q0.size() == 0) begin
          n_total++;
          $display("FAIL dut32 unexpected output: instr=%h expected none", io0);
        end else begin
          e = q0.pop_front();
          check_out("dut32", e, {32'b0, imm0}, typ0, ill0, io0);
        end
      end
      if (out_valid1) begin
        if (q1.size() == 0) begin
          n_total++;
          $display("FAIL dut64 unexpected output: instr=%h expected none", io1);
        end else begin
          e = q1.pop_front();
          check_out("dut64", e, imm1, typ1, ill1, io1);
        end
      end
      if (out_valid2) begin
        if (q2.size() == 0) begin
          n_total++;
          $display("FAIL dutnp unexpected output: instr=%h expected none", io2);
        end else begin
          e = q2.pop_front();
          check_out("dutnp", e, {32'b0, imm2}, typ2, ill2, io2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;

    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 3'd1};
    vecs[1]  = '{32'h01F01093, 64'h1F,                  32'h1F,        3'd6, 3'd6};
    vecs[2]  = '{32'h03F01093, 64'h3F,                  32'h1F,        3'd6, 3'd6};
    vecs[3]  = '{32'h80000063, 64'hFFFF_FFFF_FFFF_F000, 32'hFFFF_F000, 3'd3, 3'd3};
    vecs[4]  = '{32'h80000537, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4, 3'd4};
    vecs[5]  = '{32'h0000007F, 64'h0,                   32'h0,         3'd0, 3'd0};
    vecs[6]  = '{32'hFE000F8B, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 3'd2};
    vecs[7]  = '{32'h00112423, 64'h8,                   32'h8,         3'd2, 3'd2};
    vecs[8]  = '{32'h0080006F, 64'h8,                   32'h8,         3'd5, 3'd5};
    vecs[9]  = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd5, 3'd5};
    vecs[10] = '{32'h12345017, 64'h1234_5000,           32'h1234_5000, 3'd4, 3'd4};
    vecs[11] = '{32'h000080E7, 64'h0,                   32'h0,         3'd1, 3'd1};
    vecs[12] = '{32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd1, 3'd1};
    vecs[13] = '{32'h4010D093, 64'h1,                   32'h1,         3'd6, 3'd6};
    vecs[14] = '{32'hFFF0009B, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0,         3'd0, 3'd1};
    vecs[15] = '{32'h03F0109B, 64'h1F,                  32'h0,         3'd0, 3'd6};

    #2;
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_in_ready", in_ready0, 1'b1);
    check("rst_imm64", imm1, 64'h0);
    check("rst_type_ill_instr", {typ0, ill0, io0}, 36'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 0, 1'b1, 1'b0, acc);
    check("first_accept", acc, 1'b1);
    check("latency_1_valid", out_valid0, 1'b1);

    for (int i = 1; i < 16; i++) send(i, (i % 4) != 2);
    repeat (4) cyc(1'b0, 0, 1'b1, 1'b0, acc);
    check("drain_empty", out_valid0, 1'b0);

    // Backpressure: A and B fill main and skid, C is held off
    cyc(1'b1, 0, 1'b0, 1'b0, acc);
    check("bp_accept_a", acc, 1'b1);
    cyc(1'b1, 3, 1'b0, 1'b0, acc);
    check("bp_accept_b", acc, 1'b1);
    check("bp_ready_low", in_ready0, 1'b0);
    cyc(1'b1, 4, 1'b0, 1'b0, acc);
    check("bp_refuse_c", acc, 1'b0);
    cyc(1'b1, 4, 1'b1, 1'b0, acc);
    check("bp_refuse_c_drain", acc, 1'b0);
    check("bp_no_bubble_b", out_valid0, 1'b1);
    cyc(1'b1, 4, 1'b1, 1'b0, acc);
    check("bp_accept_c", acc, 1'b1);
    check("bp_no_bubble_c", out_valid0, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, acc);
    check("bp_done", out_valid0, 1'b0);

    // Flush with both entries full and a third input offered
    cyc(1'b1, 7, 1'b0, 1'b0, acc);
    cyc(1'b1, 8, 1'b0, 1'b0, acc);
    cyc(1'b1, 9, 1'b0, 1'b1, acc);
    check("flush_out_valid", out_valid0, 1'b0);
    check("flush_in_ready", in_ready0, 1'b1);
    repeat (3) cyc(1'b0, 0, 1'b1, 1'b0, acc);
    check("flush_nothing_out", out_valid0, 1'b0);

    // Flush coinciding with an accepted input discards that input
    cyc(1'b1, 10, 1'b0, 1'b0, acc);
    check("flush2_accept", acc, 1'b1);
    cyc(1'b1, 11, 1'b0, 1'b1, acc);
    check("flush2_out_valid", out_valid0, 1'b0);
    check("flush2_in_ready", in_ready0, 1'b1);
    repeat (2) cyc(1'b0, 0, 1'b1, 1'b0, acc);

    // Asynchronous reset in the middle of a stalled stream
    cyc(1'b1, 12, 1'b0, 1'b0, acc);
    cyc(1'b1, 13, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid0, 1'b0);
    check("mrst_in_ready", in_ready0, 1'b1);
    check("mrst_fields32", {imm0, typ0, ill0, io0}, 68'h0);
    check("mrst_imm64", imm1, 64'h0);
    q0.delete();
    q1.delete();
    q2.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      cyc(1'b0, 0, 1'b1, 1'b0, acc);
      check("mrst_idle", out_valid0, 1'b0);
    end

    check("sb_empty", {q0.size() == 0, q1.size() == 0, q2.size() == 0}, 3'b111);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
